// File: rtl/mastermind_engine.sv
// Mastermind scoring and game-state core: exact/partial counts for NUM_PEGS pegs, one colour per cycle.
// Optional macro MM_NO_REPEAT_EN: reject guesses containing a repeated colour (pulses guess_err).
module mastermind_engine #(
    parameter int NUM_PEGS   = 4,
    parameter int COLOR_BITS = 3,
    parameter int MAX_TURNS  = 8,
    localparam int CW = $clog2(NUM_PEGS + 1),
    localparam int TW = $clog2(MAX_TURNS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PEGS*COLOR_BITS-1:0] code,
    input  logic                           code_load,
    input  logic [NUM_PEGS*COLOR_BITS-1:0] guess,
    input  logic                           guess_valid,
    output logic                           ready,
    output logic                           busy,
    output logic                           score_valid,
    output logic [CW-1:0]                  exact,
    output logic [CW-1:0]                  partial,
    output logic [TW-1:0]                  turn_count,
    output logic                           win,
    output logic                           lose,
    output logic                           guess_err
);
    localparam logic [CW-1:0]         ONE_C     = CW'(1);
    localparam logic [CW-1:0]         ALL_PEGS  = CW'(NUM_PEGS);
    localparam logic [TW-1:0]         ONE_T     = TW'(1);
    localparam logic [TW-1:0]         LAST_TURN = TW'(MAX_TURNS - 1);
    localparam logic [COLOR_BITS-1:0] K_LAST    = '1;
    localparam logic [COLOR_BITS-1:0] K_ONE     = COLOR_BITS'(1);

    typedef enum logic [1:0] {IDLE, READY, SCORE, OVER} state_t;

    state_t                          state;
    logic [NUM_PEGS*COLOR_BITS-1:0]  code_r;
    logic [NUM_PEGS*COLOR_BITS-1:0]  guess_r;
    logic [CW-1:0]                   exact_r;
    logic [CW-1:0]                   acc;
    logic [COLOR_BITS-1:0]           k;

    logic [CW-1:0] exact_in, cnt_g, cnt_c, acc_next;
    logic          win_new;
    logic          repeat_in;

    always_comb begin
        exact_in  = '0;
        cnt_g     = '0;
        cnt_c     = '0;
        repeat_in = 1'b0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess[i*COLOR_BITS +: COLOR_BITS] == code_r[i*COLOR_BITS +: COLOR_BITS])
                exact_in = exact_in + ONE_C;
            if (guess_r[i*COLOR_BITS +: COLOR_BITS] == k)
                cnt_g = cnt_g + ONE_C;
            if (code_r[i*COLOR_BITS +: COLOR_BITS] == k)
                cnt_c = cnt_c + ONE_C;
            for (int j = i + 1; j < NUM_PEGS; j++)
                if (guess[i*COLOR_BITS +: COLOR_BITS] == guess[j*COLOR_BITS +: COLOR_BITS])
                    repeat_in = 1'b1;
        end
        // Sum of per-colour minima never exceeds NUM_PEGS, so CW bits suffice.
        acc_next = acc + ((cnt_g < cnt_c) ? cnt_g : cnt_c);
        win_new  = (exact_r == ALL_PEGS);
    end

    assign ready = (state == READY);
    assign busy  = (state == SCORE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            code_r      <= '0;
            guess_r     <= '0;
            exact_r     <= '0;
            acc         <= '0;
            k           <= '0;
            score_valid <= 1'b0;
            exact       <= '0;
            partial     <= '0;
            turn_count  <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (code_load) begin
                code_r     <= code;
                exact      <= '0;
                partial    <= '0;
                turn_count <= '0;
                win        <= 1'b0;
                lose       <= 1'b0;
                state      <= READY;
            end else begin
                case (state)
                    READY: begin
                        if (guess_valid
`ifdef MM_NO_REPEAT_EN
                            && !repeat_in
`endif
                        ) begin
                            guess_r <= guess;
                            exact_r <= exact_in;
                            acc     <= '0;
                            k       <= '0;
                            state   <= SCORE;
                        end
                    end
                    SCORE: begin
                        acc <= acc_next;
                        k   <= k + K_ONE;
                        if (k == K_LAST) begin
                            exact       <= exact_r;
                            partial     <= acc_next - exact_r;
                            turn_count  <= turn_count + ONE_T;
                            score_valid <= 1'b1;
                            win         <= win_new;
                            lose        <= !win_new && (turn_count == LAST_TURN);
                            state       <= (win_new || turn_count == LAST_TURN) ? OVER : READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MM_NO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset)
            guess_err <= 1'b0;
        else
            guess_err <= !code_load && (state == READY) && guess_valid && repeat_in;
    end
`else
    assign guess_err = 1'b0;
    logic unused_repeat;
    assign unused_repeat = repeat_in;
`endif

endmodule

// File: tb/tb_mastermind_engine.sv
// Directed bench for mastermind_engine at default parameters (4 pegs, 8 colours, 8 turns).
module tb_mastermind_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] code, guess;
    logic        code_load, guess_valid;
    logic        ready, busy, score_valid, win, lose, guess_err;
    logic [2:0]  exact, partial;
    logic [3:0]  turn_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mastermind_engine dut (
        .clk(clk), .reset(reset), .code(code), .code_load(code_load),
        .guess(guess), .guess_valid(guess_valid), .ready(ready), .busy(busy),
        .score_valid(score_valid), .exact(exact), .partial(partial),
        .turn_count(turn_count), .win(win), .lose(lose), .guess_err(guess_err)
    );

    localparam logic [11:0] CODE_4321 = {3'd4, 3'd3, 3'd2, 3'd1};
`ifdef MM_NO_REPEAT_EN
    localparam logic [11:0] MISS_GUESS = {3'd5, 3'd6, 3'd7, 3'd0};
`else
    localparam logic [11:0] MISS_GUESS = 12'd0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_code(input logic [11:0] c);
        code = c;
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
    endtask

    // Accept a guess, then count edges until score_valid; expected 8 edges after the accept edge.
    task automatic play_guess(input logic [11:0] g, input string tag);
        int n;
        guess = g;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        check_val({tag, "_busy"}, busy, 1);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (score_valid) break;
        end
        check_val({tag, "_latency"}, n, 8);
    endtask

    // Run cycles and count how many show score_valid.
    task automatic quiet_cycles(input int cycles, input string tag);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (score_valid) hits++;
        end
        check_val({tag, "_no_score"}, hits, 0);
    endtask

    initial begin
        reset = 1'b1; code = '0; guess = '0; code_load = 1'b0; guess_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_val("rst_ready", ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_outs", {score_valid, exact, partial, turn_count, win, lose, guess_err}, 0);

        guess = CODE_4321; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        check_val("idle_ignore", {ready, busy}, 0);

        // Test 1: win on first guess
        load_code(CODE_4321);
        check_val("t1_ready", ready, 1);
        play_guess(CODE_4321, "t1");
        check_val("t1_exact", exact, 4);
        check_val("t1_partial", partial, 0);
        check_val("t1_turn", turn_count, 1);
        check_val("t1_winlose", {win, lose}, 2'b10);
        check_val("t1_ready_over", ready, 0);
        tick();
        check_val("t1_pulse_end", score_valid, 0);
        guess = CODE_4321; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        check_val("t1_over_busy", busy, 0);
        quiet_cycles(12, "t1_over");
        check_val("t1_over_turn", turn_count, 1);

        // Test 2: all colours, wrong places
        load_code(CODE_4321);
        check_val("t2_cleared", {win, turn_count, exact}, 0);
        play_guess({3'd1, 3'd2, 3'd3, 3'd4}, "t2");
        check_val("t2_exact", exact, 0);
        check_val("t2_partial", partial, 4);
        check_val("t2_turn", turn_count, 1);
        check_val("t2_ready", ready, 1);
        check_val("t2_gerr", guess_err, 0);

`ifndef MM_NO_REPEAT_EN
        // Test 3: duplicates, code p0..p3 = 1,1,2,2; guess p0..p3 = 1,2,1,0
        load_code({3'd2, 3'd2, 3'd1, 3'd1});
        play_guess({3'd0, 3'd1, 3'd2, 3'd1}, "t3");
        check_val("t3_exact", exact, 1);
        check_val("t3_partial", partial, 2);
`endif

        // Test 4: loss after 8 misses
        load_code(CODE_4321);
        for (int i = 0; i < 8; i++) begin
            play_guess(MISS_GUESS, "t4");
            check_val("t4_score", {exact, partial}, 0);
            check_val("t4_turn", turn_count, i + 1);
            check_val("t4_lose", lose, (i == 7) ? 1 : 0);
            tick();
        end
        check_val("t4_win", win, 0);
        check_val("t4_ready", ready, 0);
        load_code(CODE_4321);
        check_val("t4_reload", {turn_count, lose}, 0);
        check_val("t4_reload_ready", ready, 1);

        // Test 5a: code_load at T+3 aborts scoring
        guess = CODE_4321; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick(); tick();
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
        check_val("t5a_ready", ready, 1);
        quiet_cycles(12, "t5a");
        check_val("t5a_turn", turn_count, 0);

        // Test 5b: code_load beats guess_valid
        code_load = 1'b1; guess_valid = 1'b1; guess = CODE_4321;
        tick();
        code_load = 1'b0; guess_valid = 1'b0;
        check_val("t5b_state", {ready, busy}, 2'b10);
        quiet_cycles(12, "t5b");
        check_val("t5b_turn", turn_count, 0);

        // Test 5c: reset mid-SCORE
        play_guess({3'd1, 3'd2, 3'd3, 3'd4}, "t5c");
        check_val("t5c_pre", partial, 4);
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t5c_state", {ready, busy}, 0);
        check_val("t5c_outs", {score_valid, exact, partial, turn_count, win, lose}, 0);
        quiet_cycles(10, "t5c");

`ifdef MM_NO_REPEAT_EN
        // Test 6: repeat rejection
        load_code(CODE_4321);
        guess = {3'd1, 3'd1, 3'd2, 3'd3}; guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        check_val("t6_gerr", guess_err, 1);
        check_val("t6_ready", ready, 1);
        tick();
        check_val("t6_gerr_pulse", guess_err, 0);
        quiet_cycles(10, "t6");
        check_val("t6_turn", turn_count, 0);
        play_guess({3'd0, 3'd1, 3'd2, 3'd3}, "t6b");
        check_val("t6b_exact", exact, 1);
        check_val("t6b_partial", partial, 2);
        check_val("t6b_turn", turn_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
